// File: rtl/abt_param.sv
// abt_param - parametrised bus arbiter for NM masters.
//
// Chooses the bus owner from the per-master request lines. Arbitration is
// run-time selectable between fixed priority (highest index wins) and
// round-robin. A parking master owns the bus when nobody requests. A lock
// watchdog breaks locked sequences that hold the bus too long.
//
// Ports:
//   CLK       in   bus clock, all state on rising edge
//   RST       in   synchronous reset, active-high
//   MODE      in   0 = fixed priority, 1 = round-robin
//   MxREQ     in   [NM] per-master request
//   MmLK      in   current transfer locked
//   MmLST     in   last transfer of current transaction
//   MsRDY     in   slave ready
//   MsERR     in   slave error
//   AxGNT     out  [NM] one-hot grant, combinational from the inputs
//   AmCMUX    out  [NM] registered one-hot CMUX select
//   AmGNT_ID  out  [IDW] registered binary index of AmCMUX
//   AmLOCK_TO out  one-cycle pulse when the watchdog forces re-arbitration
module abt_param #(
  parameter int NM       = 16,
  parameter int IDW      = 4,
  parameter int DEF_MST  = 0,
  parameter int LOCK_MAX = 64,
  parameter int CW       = 7
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           MODE,
  input  logic [NM-1:0]  MxREQ,
  input  logic           MmLK,
  input  logic           MmLST,
  input  logic           MsRDY,
  input  logic           MsERR,
  output logic [NM-1:0]  AxGNT,
  output logic [NM-1:0]  AmCMUX,
  output logic [IDW-1:0] AmGNT_ID,
  output logic           AmLOCK_TO
);

  localparam logic [NM-1:0]  ONE_OH  = {{(NM-1){1'b0}}, 1'b1};
  localparam logic [NM-1:0]  DEF_OH  = ONE_OH << DEF_MST;
  localparam logic [IDW-1:0] DEF_IDX = IDW'(DEF_MST);
  localparam logic [CW-1:0]  LK_SAT  = CW'(LOCK_MAX);
  localparam logic           WD_EN   = (LOCK_MAX != 0);

  logic [NM-1:0]  l_gnt_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [CW-1:0]  lk_cnt_r;

  logic [NM-1:0]  rr_mask_s;
  logic [NM-1:0]  req_hi_s;
  logic [IDW-1:0] next_idx_s;
  logic [NM-1:0]  next_gnt_s;
  logic           wd_hit_s;
  logic           new_abt_s;

  // Index of the highest set bit; zero when the vector is empty.
  function automatic logic [IDW-1:0] highest_idx(input logic [NM-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int j = 0; j < NM; j++) begin
      r = v[j] ? IDW'(j) : r;
    end
    return r;
  endfunction

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [IDW-1:0] lowest_idx(input logic [NM-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int j = NM - 1; j >= 0; j--) begin
      r = v[j] ? IDW'(j) : r;
    end
    return r;
  endfunction

  // Next-winner selection. Round-robin looks first at requesters above the
  // pointer; if none, the lowest requester overall wins, which naturally
  // wraps and leaves the pointer position itself as the last candidate.
  always_comb begin
    rr_mask_s = '0;
    for (int j = 0; j < NM; j++) begin
      rr_mask_s[j] = (j > int'(rr_ptr_r));
    end
    req_hi_s   = MxREQ & rr_mask_s;
    next_idx_s = DEF_IDX;
    if (MxREQ == '0) begin
      next_idx_s = DEF_IDX;
    end else if (!MODE) begin
      next_idx_s = highest_idx(MxREQ);
    end else if (req_hi_s != '0) begin
      next_idx_s = lowest_idx(req_hi_s);
    end else begin
      next_idx_s = lowest_idx(MxREQ);
    end
  end

  assign next_gnt_s = ONE_OH << next_idx_s;

  // The watchdog only fires at a transaction boundary of the locked owner.
  assign wd_hit_s  = WD_EN & (lk_cnt_r == LK_SAT) & MmLST;
  assign new_abt_s = MsERR | (MmLST & ~MmLK) | wd_hit_s;
  assign AxGNT     = new_abt_s ? next_gnt_s : l_gnt_r;

  // Owner latch, round-robin pointer, lock counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      l_gnt_r   <= DEF_OH;
      rr_ptr_r  <= DEF_IDX;
      lk_cnt_r  <= '0;
      AmCMUX    <= DEF_OH;
      AmGNT_ID  <= DEF_IDX;
      AmLOCK_TO <= 1'b0;
    end else begin
      if (MmLST || MsERR) begin
        l_gnt_r <= AxGNT;
      end
      // Parking grants do not move the pointer.
      if (new_abt_s && (MxREQ != '0)) begin
        rr_ptr_r <= next_idx_s;
      end
      if (new_abt_s || !MmLK) begin
        lk_cnt_r <= '0;
      end else if (lk_cnt_r != LK_SAT) begin
        lk_cnt_r <= lk_cnt_r + CW'(1);
      end
      if (MsRDY) begin
        AmCMUX   <= AxGNT;
        AmGNT_ID <= highest_idx(AxGNT);
      end
      // An error in the same cycle is reported as the reason instead.
      AmLOCK_TO <= wd_hit_s & ~MsERR;
    end
  end

endmodule

// File: tb/tb_abt_param.sv
// Scoreboard bench for abt_param. Three instances share the inputs:
// default watchdog (64), short watchdog (4) and watchdog disabled (0).
// Stimulus pushes hand-computed expectations per cycle; a monitor pops
// and compares them on the falling edge.
module tb_abt_param;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [15:0] req;
  logic        lk;
  logic        lst;
  logic        rdy;
  logic        err;

  logic [15:0] gnt0, cmux0, gnt1, cmux1, gnt2, cmux2;
  logic [3:0]  id0, id1, id2;
  logic        to0, to1, to2;

  abt_param dut (
    .CLK(clk), .RST(rst), .MODE(mode), .MxREQ(req), .MmLK(lk), .MmLST(lst),
    .MsRDY(rdy), .MsERR(err), .AxGNT(gnt0), .AmCMUX(cmux0), .AmGNT_ID(id0),
    .AmLOCK_TO(to0)
  );

  abt_param #(.LOCK_MAX(4)) dut_wd (
    .CLK(clk), .RST(rst), .MODE(mode), .MxREQ(req), .MmLK(lk), .MmLST(lst),
    .MsRDY(rdy), .MsERR(err), .AxGNT(gnt1), .AmCMUX(cmux1), .AmGNT_ID(id1),
    .AmLOCK_TO(to1)
  );

  abt_param #(.LOCK_MAX(0)) dut_nw (
    .CLK(clk), .RST(rst), .MODE(mode), .MxREQ(req), .MmLK(lk), .MmLST(lst),
    .MsRDY(rdy), .MsERR(err), .AxGNT(gnt2), .AmCMUX(cmux2), .AmGNT_ID(id2),
    .AmLOCK_TO(to2)
  );

  typedef struct {
    int          sel;
    int          tag;
    bit          cc;
    logic [15:0] gnt;
    logic [15:0] cmux;
    logic [3:0]  id;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic m, input logic [15:0] q,
                       input logic l, input logic s, input logic y,
                       input logic e);
    rst = r; mode = m; req = q; lk = l; lst = s; rdy = y; err = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant-only expectation.
  task automatic exp_g(input int sel, input int tag, input logic [15:0] g);
    exp_t e;
    e.sel = sel; e.tag = tag; e.cc = 1'b0; e.gnt = g;
    e.cmux = 16'h0000; e.id = 4'h0; e.to = 1'b0;
    sb_q.push_back(e);
  endtask

  // Full expectation: grant, CMUX, ID and lock-timeout pulse.
  task automatic exp_a(input int sel, input int tag, input logic [15:0] g,
                       input logic [15:0] c, input logic [3:0] id,
                       input logic to);
    exp_t e;
    e.sel = sel; e.tag = tag; e.cc = 1'b1; e.gnt = g;
    e.cmux = c; e.id = id; e.to = to;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int sel, input int tag,
                     input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d step %0d: got %h, expected %h",
               name, sel, tag, act, want);
    end
  endtask

  // Monitor: drains all expectations for the current cycle.
  initial begin
    exp_t        e;
    logic [15:0] ag, ac;
    logic [3:0]  ai;
    logic        at;
    forever begin
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          1:       begin ag = gnt1; ac = cmux1; ai = id1; at = to1; end
          2:       begin ag = gnt2; ac = cmux2; ai = id2; at = to2; end
          default: begin ag = gnt0; ac = cmux0; ai = id0; at = to0; end
        endcase
        cmp("gnt", e.sel, e.tag, ag, e.gnt);
        if (e.cc) begin
          cmp("cmux", e.sel, e.tag, ac, e.cmux);
          cmp("gnt_id", e.sel, e.tag, {12'h000, ai}, {12'h000, e.id});
          cmp("lock_to", e.sel, e.tag, {15'h0000, at}, {15'h0000, e.to});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) exp_a(s, 1, 16'h0001, 16'h0001, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_a(0, 2, 16'h0001, 16'h0001, 4'd0, 1'b0); tick();

    // Fixed priority
    drive(1'b0, 1'b0, 16'h0012, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_a(0, 3, 16'h0010, 16'h0001, 4'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_a(0, 4, 16'h0010, 16'h0010, 4'd4, 1'b0); tick();

    // Round-robin from reset (reset mid-ownership discards owner)
    drive(1'b1, 1'b1, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 16'h0015, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_a(0, 10, 16'h0004, 16'h0001, 4'd0, 1'b0); tick();
    exp_a(0, 11, 16'h0010, 16'h0004, 4'd2, 1'b0); tick();
    exp_a(0, 12, 16'h0001, 16'h0010, 4'd4, 1'b0); tick();
    exp_a(0, 13, 16'h0004, 16'h0001, 4'd0, 1'b0); tick();

    // Lock hold with the default watchdog
    drive(1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_a(0, 20, 16'h0008, 16'h0004, 4'd2, 1'b0); tick();
    drive(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_a(0, 21 + i, 16'h0008, 16'h0008, 4'd3, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_a(0, 31, 16'h8000, 16'h0008, 4'd3, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_a(0, 32, 16'h8000, 16'h8000, 4'd15, 1'b0); tick();

    // Watchdog: LOCK_MAX=4 breaks the lock, LOCK_MAX=0 does not
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) exp_a(s, 40, 16'h0001, 16'h0001, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) exp_a(s, 41, 16'h0008, 16'h0001, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0108, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_a(1, 42 + i, 16'h0008, 16'h0008, 4'd3, 1'b0);
      exp_a(2, 42 + i, 16'h0008, 16'h0008, 4'd3, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0108, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_a(1, 46, 16'h0100, 16'h0008, 4'd3, 1'b0);
    exp_a(2, 46, 16'h0008, 16'h0008, 4'd3, 1'b0);
    exp_g(0, 46, 16'h0008);
    tick();
    drive(1'b0, 1'b0, 16'h0108, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_a(1, 47, 16'h0100, 16'h0100, 4'd8, 1'b1);
    exp_a(2, 47, 16'h0008, 16'h0008, 4'd3, 1'b0);
    tick();
    exp_a(1, 48, 16'h0100, 16'h0100, 4'd8, 1'b0); tick();

    // Error overrides lock; ready stall holds the CMUX select
    drive(1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_a(0, 50, 16'h0100, 16'h0008, 4'd3, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_a(0, 51, 16'h0100, 16'h0008, 4'd3, 1'b0); tick();
    exp_a(0, 52, 16'h0100, 16'h0008, 4'd3, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_a(0, 53, 16'h0100, 16'h0008, 4'd3, 1'b0); tick();
    exp_a(0, 54, 16'h0100, 16'h0100, 4'd8, 1'b0); tick();

    // Error coinciding with a watchdog hit: no timeout pulse
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_g(1, 60, 16'h0008); tick();
    drive(1'b0, 1'b0, 16'h0108, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_g(1, 61 + i, 16'h0008); tick();
    end
    drive(1'b0, 1'b0, 16'h0108, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_a(1, 65, 16'h0100, 16'h0008, 4'd3, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0108, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_a(1, 66, 16'h0100, 16'h0100, 4'd8, 1'b0); tick();

    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
